// File: rtl/regfile_scoreboard_if.sv
// Register-file port bundle: read ports, write ports, allocation and scoreboard outputs.
// Fields are packed per port (port i at [i*W +: W]); the master drives requests, the slave answers.
interface regfile_scoreboard_if #(
    parameter int REG_NUM         = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int NUM_READ_PORTS  = 4,
    parameter int NUM_WRITE_PORTS = 2
);
    localparam int AW = $clog2(REG_NUM);

    logic [NUM_READ_PORTS-1:0]             rdEn;
    logic [NUM_READ_PORTS*AW-1:0]          rdAddr;
    logic [NUM_READ_PORTS*DATA_WIDTH-1:0]  rdData;
    logic [NUM_READ_PORTS-1:0]             rdBusy;
    logic [NUM_WRITE_PORTS-1:0]            wrEn;
    logic [NUM_WRITE_PORTS*AW-1:0]         wrAddr;
    logic [NUM_WRITE_PORTS*DATA_WIDTH-1:0] wrData;
    logic                                  allocEn;
    logic [AW-1:0]                         allocAddr;
    logic [REG_NUM-1:0]                    busyVec;
    logic                                  conflict;

    modport master (
        output rdEn, rdAddr, wrEn, wrAddr, wrData, allocEn, allocAddr,
        input  rdData, rdBusy, busyVec, conflict
    );

    modport slave (
        input  rdEn, rdAddr, wrEn, wrAddr, wrData, allocEn, allocAddr,
        output rdData, rdBusy, busyVec, conflict
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// Multi-ported register file with per-register busy scoreboard; REGFILE_BYPASS_EN adds write-to-read forwarding.
// Latency: reads registered, 1 cycle; writes/allocations visible after the edge.
// Backpressure: none, every request is accepted every cycle.
module regfile_scoreboard #(
    parameter int REG_NUM         = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int NUM_READ_PORTS  = 4,
    parameter int NUM_WRITE_PORTS = 2,
    parameter int ZERO_REG        = 1
) (
    input logic                 clk,
    input logic                 rstN,
    regfile_scoreboard_if.slave bus
);
    localparam int AW = $clog2(REG_NUM);

    typedef logic [DATA_WIDTH-1:0] data_t;
    typedef logic [AW-1:0]         addr_t;

    data_t                     regs_q    [REG_NUM];
    data_t                     regs_d    [REG_NUM];
    logic [REG_NUM-1:0]        busy_q;
    logic [REG_NUM-1:0]        busy_d;
    data_t                     rd_data_q [NUM_READ_PORTS];
    data_t                     rd_data_d [NUM_READ_PORTS];
    logic [NUM_READ_PORTS-1:0] rd_busy_q;
    logic [NUM_READ_PORTS-1:0] rd_busy_d;
    logic                      conflict_q;
    logic                      conflict_d;

    function automatic logic is_writable(addr_t a);
        return !((ZERO_REG != 0) && (a == '0));
    endfunction

    always_comb begin
        logic [REG_NUM-1:0] wr_hit;
        data_t              wr_val [REG_NUM];
        addr_t              wa;
        addr_t              ra;

        wr_hit     = '0;
        wa         = '0;
        ra         = '0;
        conflict_d = 1'b0;
        for (int r = 0; r < REG_NUM; r++) begin
            wr_val[r] = '0;
        end

        // Ascending scan: a later (higher-indexed) port overwrites the winner.
        for (int w = 0; w < NUM_WRITE_PORTS; w++) begin
            wa = bus.wrAddr[w*AW +: AW];
            if (bus.wrEn[w] && is_writable(wa)) begin
                if (wr_hit[wa]) begin
                    conflict_d = 1'b1;
                end
                wr_hit[wa] = 1'b1;
                wr_val[wa] = bus.wrData[w*DATA_WIDTH +: DATA_WIDTH];
            end
        end

        regs_d = regs_q;
        busy_d = busy_q;
        for (int r = 0; r < REG_NUM; r++) begin
            if (wr_hit[r]) begin
                regs_d[r] = wr_val[r];
                busy_d[r] = 1'b0;
            end
        end
        // A new producer supersedes a same-edge writeback.
        if (bus.allocEn && is_writable(bus.allocAddr)) begin
            busy_d[bus.allocAddr] = 1'b1;
        end

        rd_data_d = rd_data_q;
        rd_busy_d = rd_busy_q;
        for (int i = 0; i < NUM_READ_PORTS; i++) begin
            if (bus.rdEn[i]) begin
                ra = bus.rdAddr[i*AW +: AW];
`ifdef REGFILE_BYPASS_EN
                if (wr_hit[ra]) begin
                    rd_data_d[i] = wr_val[ra];
                    rd_busy_d[i] = busy_d[ra];
                end else begin
                    rd_data_d[i] = regs_q[ra];
                    rd_busy_d[i] = busy_q[ra];
                end
`else
                rd_data_d[i] = regs_q[ra];
                rd_busy_d[i] = busy_q[ra];
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            regs_q     <= '{default: '0};
            busy_q     <= '0;
            rd_data_q  <= '{default: '0};
            rd_busy_q  <= '0;
            conflict_q <= 1'b0;
        end else begin
            regs_q     <= regs_d;
            busy_q     <= busy_d;
            rd_data_q  <= rd_data_d;
            rd_busy_q  <= rd_busy_d;
            conflict_q <= conflict_d;
        end
    end

    for (genvar g = 0; g < NUM_READ_PORTS; g++) begin : g_rd_out
        assign bus.rdData[g*DATA_WIDTH +: DATA_WIDTH] = rd_data_q[g];
    end
    assign bus.rdBusy   = rd_busy_q;
    assign bus.busyVec  = busy_q;
    assign bus.conflict = conflict_q;
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Scoreboard bench: two instances (ZERO_REG=0 and ZERO_REG=1) share stimulus; a reference model
// pushes per-edge expectations and a negedge monitor compares them with the DUT outputs.
module tb_regfile_scoreboard;
    localparam int RN = 32;
    localparam int DW = 32;
    localparam int NR = 4;
    localparam int NW = 2;
    localparam int AW = $clog2(RN);
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk;
    logic rstN;
    int   edge_cnt = 0;
    int   checks   = 0;
    int   errors   = 0;

    regfile_scoreboard_if #(.REG_NUM(RN), .DATA_WIDTH(DW), .NUM_READ_PORTS(NR), .NUM_WRITE_PORTS(NW)) bus0 ();
    regfile_scoreboard_if #(.REG_NUM(RN), .DATA_WIDTH(DW), .NUM_READ_PORTS(NR), .NUM_WRITE_PORTS(NW)) bus1 ();

    regfile_scoreboard #(.REG_NUM(RN), .DATA_WIDTH(DW), .NUM_READ_PORTS(NR), .NUM_WRITE_PORTS(NW), .ZERO_REG(0))
        u_dut0 (.clk(clk), .rstN(rstN), .bus(bus0));
    regfile_scoreboard #(.REG_NUM(RN), .DATA_WIDTH(DW), .NUM_READ_PORTS(NR), .NUM_WRITE_PORTS(NW), .ZERO_REG(1))
        u_dut1 (.clk(clk), .rstN(rstN), .bus(bus1));

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt++;

    // Stimulus for the upcoming edge.
    logic           t_rd_en   [NR];
    int             t_rd_addr [NR];
    logic           t_wr_en   [NW];
    int             t_wr_addr [NW];
    logic [DW-1:0]  t_wr_data [NW];
    logic           t_alloc_en;
    int             t_alloc_addr;

    // Reference state, index 0 = ZERO_REG=0 instance, 1 = ZERO_REG=1 instance.
    logic [DW-1:0] m_reg  [2][RN];
    logic          m_busy [2][RN];
    logic [DW-1:0] m_rd   [2][NR];
    logic          m_rdb  [2][NR];

    typedef struct packed {
        int                   tag;
        int                   inst;
        logic [NR-1:0][DW-1:0] rd;
        logic [NR-1:0]        rdb;
        logic [RN-1:0]        bvec;
        logic                 conf;
    } exp_t;

    exp_t expq[$];
    exp_t e;

    task automatic chk(input string nm, input logic [NR*DW-1:0] act, input logic [NR*DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic bit wr_ok(input int inst, input int a);
        return !(inst == 1 && a == 0);
    endfunction

    task automatic model_reset();
        for (int z = 0; z < 2; z++) begin
            for (int r = 0; r < RN; r++) begin
                m_reg[z][r]  = '0;
                m_busy[z][r] = 1'b0;
            end
            for (int p = 0; p < NR; p++) begin
                m_rd[z][p]  = '0;
                m_rdb[z][p] = 1'b0;
            end
        end
    endtask

    task automatic model_step(input int z, input int tag);
        logic [DW-1:0] nreg  [RN];
        logic          nbusy [RN];
        logic          hit   [RN];
        logic          conf;
        exp_t          x;
        conf = 1'b0;
        for (int r = 0; r < RN; r++) begin
            nreg[r]  = m_reg[z][r];
            nbusy[r] = m_busy[z][r];
            hit[r]   = 1'b0;
        end
        for (int p = 0; p < NW; p++)
            for (int q = p + 1; q < NW; q++)
                if (t_wr_en[p] && t_wr_en[q] && t_wr_addr[p] == t_wr_addr[q] && wr_ok(z, t_wr_addr[p]))
                    conf = 1'b1;
        for (int p = 0; p < NW; p++) begin
            if (t_wr_en[p] && wr_ok(z, t_wr_addr[p])) begin
                hit[t_wr_addr[p]]   = 1'b1;
                nreg[t_wr_addr[p]]  = t_wr_data[p];
                nbusy[t_wr_addr[p]] = 1'b0;
            end
        end
        if (t_alloc_en && wr_ok(z, t_alloc_addr)) nbusy[t_alloc_addr] = 1'b1;
        for (int p = 0; p < NR; p++) begin
            if (t_rd_en[p]) begin
                if (BYP && hit[t_rd_addr[p]]) begin
                    m_rd[z][p]  = nreg[t_rd_addr[p]];
                    m_rdb[z][p] = nbusy[t_rd_addr[p]];
                end else begin
                    m_rd[z][p]  = m_reg[z][t_rd_addr[p]];
                    m_rdb[z][p] = m_busy[z][t_rd_addr[p]];
                end
            end
        end
        for (int r = 0; r < RN; r++) begin
            m_reg[z][r]  = nreg[r];
            m_busy[z][r] = nbusy[r];
        end
        x.tag  = tag;
        x.inst = z;
        x.conf = conf;
        for (int p = 0; p < NR; p++) begin
            x.rd[p]  = m_rd[z][p];
            x.rdb[p] = m_rdb[z][p];
        end
        for (int r = 0; r < RN; r++) x.bvec[r] = m_busy[z][r];
        expq.push_back(x);
    endtask

    task automatic clear_inputs();
        for (int p = 0; p < NR; p++) begin t_rd_en[p] = 1'b0; t_rd_addr[p] = 0; end
        for (int p = 0; p < NW; p++) begin t_wr_en[p] = 1'b0; t_wr_addr[p] = 0; t_wr_data[p] = '0; end
        t_alloc_en   = 1'b0;
        t_alloc_addr = 0;
    endtask

    task automatic apply();
        for (int p = 0; p < NR; p++) begin
            bus0.rdEn[p] = t_rd_en[p];  bus0.rdAddr[p*AW +: AW] = AW'(t_rd_addr[p]);
            bus1.rdEn[p] = t_rd_en[p];  bus1.rdAddr[p*AW +: AW] = AW'(t_rd_addr[p]);
        end
        for (int p = 0; p < NW; p++) begin
            bus0.wrEn[p] = t_wr_en[p];  bus0.wrAddr[p*AW +: AW] = AW'(t_wr_addr[p]);
            bus1.wrEn[p] = t_wr_en[p];  bus1.wrAddr[p*AW +: AW] = AW'(t_wr_addr[p]);
            bus0.wrData[p*DW +: DW] = t_wr_data[p];
            bus1.wrData[p*DW +: DW] = t_wr_data[p];
        end
        bus0.allocEn = t_alloc_en;  bus0.allocAddr = AW'(t_alloc_addr);
        bus1.allocEn = t_alloc_en;  bus1.allocAddr = AW'(t_alloc_addr);
    endtask

    // Drives one edge worth of stimulus, records expectations, returns #1 after the edge.
    task automatic step();
        apply();
        model_step(0, edge_cnt + 1);
        model_step(1, edge_cnt + 1);
        @(posedge clk);
        #1;
        clear_inputs();
        apply();
    endtask

    task automatic wr(input int p, input int a, input logic [DW-1:0] d);
        t_wr_en[p] = 1'b1; t_wr_addr[p] = a; t_wr_data[p] = d;
    endtask

    task automatic rd(input int p, input int a);
        t_rd_en[p] = 1'b1; t_rd_addr[p] = a;
    endtask

    task automatic check_all_zero(input string nm);
        chk({nm, " rdData0"},  bus0.rdData, '0);
        chk({nm, " rdData1"},  bus1.rdData, '0);
        chk({nm, " rdBusy0"},  {{(NR*DW-NR){1'b0}}, bus0.rdBusy}, '0);
        chk({nm, " busyVec0"}, {{(NR*DW-RN){1'b0}}, bus0.busyVec}, '0);
        chk({nm, " busyVec1"}, {{(NR*DW-RN){1'b0}}, bus1.busyVec}, '0);
        chk({nm, " conflict"}, {{(NR*DW-2){1'b0}}, bus0.conflict, bus1.conflict}, '0);
    endtask

    // Monitor: compare every expectation whose edge has passed.
    always @(negedge clk) begin
        while (expq.size() > 0 && expq[0].tag <= edge_cnt) begin
            e = expq.pop_front();
            if (e.inst == 0) begin
                chk($sformatf("i0 e%0d rdData", e.tag), bus0.rdData, e.rd);
                chk($sformatf("i0 e%0d rdBusy", e.tag), {{(NR*DW-NR){1'b0}}, bus0.rdBusy}, {{(NR*DW-NR){1'b0}}, e.rdb});
                chk($sformatf("i0 e%0d busyVec", e.tag), {{(NR*DW-RN){1'b0}}, bus0.busyVec}, {{(NR*DW-RN){1'b0}}, e.bvec});
                chk($sformatf("i0 e%0d conflict", e.tag), {{(NR*DW-1){1'b0}}, bus0.conflict}, {{(NR*DW-1){1'b0}}, e.conf});
            end else begin
                chk($sformatf("i1 e%0d rdData", e.tag), bus1.rdData, e.rd);
                chk($sformatf("i1 e%0d rdBusy", e.tag), {{(NR*DW-NR){1'b0}}, bus1.rdBusy}, {{(NR*DW-NR){1'b0}}, e.rdb});
                chk($sformatf("i1 e%0d busyVec", e.tag), {{(NR*DW-RN){1'b0}}, bus1.busyVec}, {{(NR*DW-RN){1'b0}}, e.bvec});
                chk($sformatf("i1 e%0d conflict", e.tag), {{(NR*DW-1){1'b0}}, bus1.conflict}, {{(NR*DW-1){1'b0}}, e.conf});
            end
        end
    end

    function automatic int rnd_addr();
        return ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, RN - 1)) : int'($urandom_range(0, 7));
    endfunction

    initial begin
        rstN = 1'b0;
        clear_inputs();
        apply();
        model_reset();
        #1;
        check_all_zero("reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstN = 1'b1;

        // Populate state, then reset mid-cycle and confirm it clears at once.
        wr(0, 5, 32'hDEADBEEF); t_alloc_en = 1'b1; t_alloc_addr = 6; step();
        rd(0, 5); rd(1, 6); step();
        @(negedge clk);
        #2;
        rstN = 1'b0;
        #1;
        check_all_zero("midreset");
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rstN = 1'b1;
        rd(0, 5); step();
        step();

        // Broadcast read and hold.
        wr(0, 3, 32'h1234); step();
        for (int p = 0; p < NR; p++) rd(p, 3);
        step();
        step();

        // Write collision on r7 and on r0.
        wr(0, 7, 32'hAAAA); wr(1, 7, 32'hBBBB); step();
        rd(0, 7); step();
        wr(0, 0, 32'h1111); wr(1, 0, 32'h2222); step();
        rd(1, 0); step();

        // Scoreboard allocate / clear / allocate-wins.
        t_alloc_en = 1'b1; t_alloc_addr = 9; step();
        rd(2, 9); step();
        wr(1, 9, 32'h9); step();
        wr(0, 9, 32'h99); t_alloc_en = 1'b1; t_alloc_addr = 9; step();
        rd(3, 9); step();

        // Same-edge read/write of r4.
        wr(0, 4, 32'h11); step();
        wr(1, 4, 32'h22); rd(0, 4); step();
        rd(1, 4); step();

        // Register 0 as an ordinary register on instance 0.
        wr(0, 0, 32'h55); step();
        rd(0, 0); t_alloc_en = 1'b1; t_alloc_addr = 0; step();
        step();

        for (int n = 0; n < 400; n++) begin
            for (int p = 0; p < NR; p++) begin
                t_rd_en[p]   = 1'($urandom_range(0, 1));
                t_rd_addr[p] = rnd_addr();
            end
            for (int p = 0; p < NW; p++) begin
                t_wr_en[p]   = 1'($urandom_range(0, 1));
                t_wr_addr[p] = rnd_addr();
                t_wr_data[p] = DW'($urandom);
            end
            t_alloc_en   = 1'($urandom_range(0, 1));
            t_alloc_addr = rnd_addr();
            step();
        end

        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
